// File: rtl/rec_arbiter.sv
// rec_arbiter
// Collects branch-mispredict recovery requests from N_REQ resolution units and
// drives the single recovery port of the renaming unit. It always issues the
// oldest pending request relative to the ROB head, blocks further recoveries
// until the renamer finishes its RHT walk, and drops requests that the issued
// recovery has made wrong-path.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous, active-high reset
//   req_valid   per-requester valid
//   req_rob_id  flattened N_REQ x ROB_W ROB ids (requester i at [i*ROB_W +: ROB_W])
//   req_rht_id  flattened N_REQ x RHT_W RHT ids
//   req_ready   per-requester slot empty; accept on valid & ready
//   rob_head    ROB commit pointer (oldest in-flight)
//   rec_en      one-cycle recovery strobe
//   rec_rob_id  recovered ROB id (held until the next selection)
//   rec_rht_id  recovered RHT id (held until the next selection)
//   rec_busy    renamer walk in progress
//   rec_count   recoveries issued, saturating at 16'hFFFF
module rec_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ROB_DEPTH = 96,
  parameter int RHT_DEPTH = 128,
  parameter int K         = 32,
  localparam int ROB_W    = $clog2(ROB_DEPTH),
  localparam int RHT_W    = $clog2(RHT_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ROB_W-1:0]   req_rob_id,
  input  logic [N_REQ*RHT_W-1:0]   req_rht_id,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [ROB_W-1:0]         rob_head,
  output logic                     rec_en,
  output logic [ROB_W-1:0]         rec_rob_id,
  output logic [RHT_W-1:0]         rec_rht_id,
  input  logic                     rec_busy,
  output logic [15:0]              rec_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   slot_valid_q, slot_valid_d;
  logic [ROB_W-1:0]   slot_rob_q [N_REQ];
  logic [ROB_W-1:0]   slot_rob_d [N_REQ];
  logic [RHT_W-1:0]   slot_rht_q [N_REQ];
  logic [RHT_W-1:0]   slot_rht_d [N_REQ];
  logic [ROB_W-1:0]   rec_rob_id_q, rec_rob_id_d;
  logic [RHT_W-1:0]   rec_rht_id_q, rec_rht_id_d;
  logic [ROB_W-1:0]   win_age_q, win_age_d;
  logic [15:0]        rec_count_q, rec_count_d;

  logic [ROB_W-1:0]   slot_age [N_REQ];
  logic [ROB_W-1:0]   req_age  [N_REQ];
  logic [N_REQ-1:0]   accept;
  logic               any_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [ROB_W-1:0]   best_age;

  // Distance from the ROB head. The wrap branch may overflow ROB_W bits in the
  // intermediate sum, but the true result is < ROB_DEPTH so modular arithmetic
  // still yields the right value.
  function automatic logic [ROB_W-1:0] age_of(input logic [ROB_W-1:0] id,
                                               input logic [ROB_W-1:0] head);
    if (id >= head) return id - head;
    else            return id + ROB_W'(ROB_DEPTH) - head;
  endfunction

  assign req_ready  = ~slot_valid_q;
  assign rec_en     = (state_q == ISSUE);
  assign rec_rob_id = rec_rob_id_q;
  assign rec_rht_id = rec_rht_id_q;
  assign rec_count  = rec_count_q;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      slot_age[i] = age_of(slot_rob_q[i], rob_head);
      req_age[i]  = age_of(req_rob_id[i*ROB_W +: ROB_W], rob_head);
    end
  end

  // Oldest valid slot; strict less-than keeps the lowest index on ties.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    best_age  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (slot_valid_q[i] && (!any_valid || slot_age[i] < best_age)) begin
        any_valid = 1'b1;
        win_idx   = IDX_W'(i);
        best_age  = slot_age[i];
      end
    end
  end

  // While a recovery is in flight, only requests older than it are kept.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      accept[i] = req_valid[i] && !slot_valid_q[i] &&
                  ((state_q == IDLE) || (req_age[i] < win_age_q));
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_valid_d = slot_valid_q;
    slot_rob_d   = slot_rob_q;
    slot_rht_d   = slot_rht_q;
    rec_rob_id_d = rec_rob_id_q;
    rec_rht_id_d = rec_rht_id_q;
    win_age_d    = win_age_q;
    rec_count_d  = rec_count_q;

    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          rec_rob_id_d          = slot_rob_q[win_idx];
          rec_rht_id_d          = slot_rht_q[win_idx];
          win_age_d             = best_age;
          slot_valid_d[win_idx] = 1'b0;
          state_d               = ISSUE;
        end
      end
      ISSUE: begin
        if (rec_count_q != 16'hFFFF) rec_count_d = rec_count_q + 16'd1;
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (slot_valid_q[i] && slot_age[i] >= win_age_q) slot_valid_d[i] = 1'b0;
        end
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!rec_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accepts only target empty slots, so they never collide with the clears above.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_rob_d[i]   = req_rob_id[i*ROB_W +: ROB_W];
        slot_rht_d[i]   = req_rht_id[i*RHT_W +: RHT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_valid_q <= '0;
      slot_rob_q   <= '{default: '0};
      slot_rht_q   <= '{default: '0};
      rec_rob_id_q <= '0;
      rec_rht_id_q <= '0;
      win_age_q    <= '0;
      rec_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      slot_rob_q   <= slot_rob_d;
      slot_rht_q   <= slot_rht_d;
      rec_rob_id_q <= rec_rob_id_d;
      rec_rht_id_q <= rec_rht_id_d;
      win_age_q    <= win_age_d;
      rec_count_q  <= rec_count_d;
    end
  end

  // ROB and RHT ids of one instruction agree modulo the checkpoint period.
  for (genvar g = 0; g < N_REQ; g++) begin : g_align
    a_align: assert property (@(posedge clk) disable iff (rst)
      (req_valid[g] && req_ready[g]) |->
        ((int'(req_rht_id[g*RHT_W +: RHT_W]) % K) == (int'(req_rob_id[g*ROB_W +: ROB_W]) % K)));
  end

endmodule

// File: tb/tb_rec_arbiter.sv
module tb_rec_arbiter;

  localparam int N_REQ = 4;
  localparam int ROB_W = 7;
  localparam int RHT_W = 7;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*ROB_W-1:0] req_rob_id = '0;
  logic [N_REQ*RHT_W-1:0] req_rht_id = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [ROB_W-1:0]       rob_head = '0;
  logic                   rec_en;
  logic [ROB_W-1:0]       rec_rob_id;
  logic [RHT_W-1:0]       rec_rht_id;
  logic                   rec_busy = 1'b0;
  logic [15:0]            rec_count;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int exp_count = 0;
  bit seen;

  logic [ROB_W+RHT_W-1:0] sb [$];

  rec_arbiter #(.N_REQ(4), .ROB_DEPTH(96), .RHT_DEPTH(128), .K(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rob_id(req_rob_id), .req_rht_id(req_rht_id),
    .req_ready(req_ready), .rob_head(rob_head),
    .rec_en(rec_en), .rec_rob_id(rec_rob_id), .rec_rht_id(rec_rht_id),
    .rec_busy(rec_busy), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ROB_W-1:0] rob, input logic [RHT_W-1:0] rht);
    req_valid[i] = 1'b1;
    req_rob_id[i*ROB_W +: ROB_W] = rob;
    req_rht_id[i*RHT_W +: RHT_W] = rht;
  endtask

  task automatic expect_rec(input logic [ROB_W-1:0] rob, input logic [RHT_W-1:0] rht);
    sb.push_back({rob, rht});
    exp_pulses++;
    exp_count++;
  endtask

  // Scoreboard: every strobe must match the oldest expected recovery.
  always @(negedge clk) begin
    logic [ROB_W+RHT_W-1:0] e;
    if (!rst && rec_en) begin
      pulses++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_rec observed rob=%0d rht=%0d expected no strobe", rec_rob_id, rec_rht_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_rob", rec_rob_id, e[ROB_W+RHT_W-1:RHT_W]);
        chk("sb_rht", rec_rht_id, e[RHT_W-1:0]);
      end
    end
  end

  initial begin
    // Reset state
    #1;
    chk("rst_en", rec_en, 0);
    chk("rst_ready", req_ready, 4'hF);
    chk("rst_count", rec_count, 0);
    chk("rst_rob", rec_rob_id, 0);
    chk("rst_rht", rec_rht_id, 0);
    #12 rst = 1'b0;
    tick();

    // 1: reset pulse mid-DRAIN with an older request stored
    rob_head = 7'd0;
    set_req(0, 7'd50, 7'd82); expect_rec(7'd50, 7'd82);
    tick(); req_valid = '0;
    tick();
    chk("s1_en", rec_en, 1);
    rec_busy = 1'b1;
    tick();
    set_req(1, 7'd5, 7'd37);
    tick(); req_valid = '0;
    chk("s1_ready_stored", req_ready, 4'b1101);
    #2 rst = 1'b1;
    #1;
    chk("s1_rst_en", rec_en, 0);
    chk("s1_rst_ready", req_ready, 4'hF);
    chk("s1_rst_count", rec_count, 0);
    exp_count = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0; rec_busy = 1'b0;
    tick();
    chk("s1_post_rob", rec_rob_id, 0);
    chk("s1_post_rht", rec_rht_id, 0);

    // 2: basic latency, busy held 5 cycles
    set_req(0, 7'd10, 7'd42); expect_rec(7'd10, 7'd42);
    tick(); req_valid = '0;
    chk("s2_en_e0", rec_en, 0);
    chk("s2_ready_e0", req_ready, 4'hE);
    tick();
    chk("s2_en_e1", rec_en, 1);
    chk("s2_rob", rec_rob_id, 10);
    chk("s2_rht", rec_rht_id, 42);
    rec_busy = 1'b1;
    tick();
    chk("s2_en_e2", rec_en, 0);
    repeat (4) tick();
    rec_busy = 1'b0;
    tick();
    chk("s2_count", rec_count, exp_count);

    // 3: head=90, rob=92 (age 2) beats rob=5 (age 11); rob=5 squashed
    rob_head = 7'd90;
    set_req(1, 7'd5, 7'd37);
    set_req(2, 7'd92, 7'd124); expect_rec(7'd92, 7'd124);
    tick(); req_valid = '0;
    chk("s3_ready_e0", req_ready, 4'b1001);
    tick();
    chk("s3_en", rec_en, 1);
    chk("s3_ready_issue", req_ready, 4'b1101);
    rec_busy = 1'b1;
    tick();
    chk("s3_ready_drain", req_ready, 4'hF);
    rec_busy = 1'b0;
    repeat (4) tick();
    chk("s3_pulses", pulses, exp_pulses);

    // 4: equal ids, lowest index wins
    rob_head = 7'd0;
    set_req(0, 7'd20, 7'd52); expect_rec(7'd20, 7'd52);
    set_req(3, 7'd20, 7'd20);
    tick(); req_valid = '0;
    tick();
    chk("s4_rht", rec_rht_id, 52);
    chk("s4_ready_issue", req_ready, 4'b0111);
    tick();
    chk("s4_ready_drain", req_ready, 4'hF);
    repeat (4) tick();
    chk("s4_pulses", pulses, exp_pulses);

    // 5: younger request in DRAIN dropped, older one stored and issued later
    set_req(0, 7'd30, 7'd62); expect_rec(7'd30, 7'd62);
    tick(); req_valid = '0;
    tick();
    rec_busy = 1'b1;
    tick();
    set_req(1, 7'd40, 7'd72);
    chk("s5_ready_pre", req_ready[1], 1);
    tick(); req_valid = '0;
    chk("s5_dropped", req_ready, 4'hF);
    set_req(2, 7'd12, 7'd44); expect_rec(7'd12, 7'd44);
    tick(); req_valid = '0;
    chk("s5_stored", req_ready, 4'b1011);
    repeat (2) tick();
    chk("s5_hold_en", rec_en, 0);
    rec_busy = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      tick();
      if (rec_en) seen = 1'b1;
    end
    chk("s5_second_issue", seen, 1);
    repeat (3) tick();
    chk("s5_count", rec_count, exp_count);

    // 6: head=95, rob=0 (age 1) beats rob=94 (age 95)
    rob_head = 7'd95;
    set_req(0, 7'd94, 7'd126);
    set_req(1, 7'd0, 7'd32); expect_rec(7'd0, 7'd32);
    tick(); req_valid = '0;
    tick();
    chk("s6_rob", rec_rob_id, 0);
    chk("s6_ready_issue", req_ready, 4'b1111 & ~4'b0001 | 4'b0000);
    tick();
    chk("s6_ready_drain", req_ready, 4'hF);
    repeat (4) tick();

    chk("end_sb_empty", sb.size(), 0);
    chk("end_pulses", pulses, exp_pulses);
    chk("end_count", rec_count, exp_count);
    chk("end_hold_rob", rec_rob_id, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $error("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
